io_led_bank: RTL and testbench
==============================

# io_led_bank

Parametrised memory-mapped LED/GPIO output bank for the TinyComp I/O bus, replacing the single fixed-address 8-bit LED latch. It decodes an address window and provides write, set, clear and toggle registers. Per-channel PWM dimming is driven by a prescaled counter, and registers can be read back through the bus read handshake. It sits beside the CPU in the board top level. `leds` drives the pins, and `Hit` steers the top-level `InData` mux.

## Interface
- `BASE_ADDR`, 32'h000003C0: word address of offset 0. Must be 64-aligned; the window is offsets 0..63.
- `NUM_LEDS`, 8: channel count, 1..32.
- `PWM_BITS`, 8: duty resolution, 2..16.
- `PRESCALE`, 40: clocks per PWM counter step, ≥1.
- `clk` in 1: single clock, rising edge.
- `Reset_n` in 1: **asynchronous, active-low** reset.
- `IOaddr` in 32: bus address.
- `OutData` in 32: write data.
- `OutStrobe` in 1: one-cycle write strobe.
- `InStrobe` in 1: one-cycle read strobe.
- `InData` out 32: read data.
- `InRdy` out 1: read-data-valid pulse.
- `Hit` out 1: combinational, `IOaddr` is inside the window.
- `leds` out NUM_LEDS: registered channel outputs.

## Operation
- **Offset.** off = IOaddr − BASE_ADDR. Hit = (IOaddr[31:6] == BASE_ADDR[31:6]). Strobes with Hit=0 are ignored.
- **Registers.** Writes use the low NUM_LEDS bits unless stated.
  - 0 LED, read/write: write replaces.
  - 1 SET, write only: LED |= data.
  - 2 CLR, write only: LED &= ~data.
  - 3 TOG, write only: LED ^= data.
  - 4 PWM_EN, read/write: per-channel PWM enable.
  - 5 ID, read only: {NUM_LEDS[7:0], PWM_BITS[7:0], 16'h1ED0}.
  - 8+i DUTY[i], read/write, i < NUM_LEDS: low PWM_BITS bits.
- **Reads.** Reading a write-only or unmapped offset returns 0. Writes to read-only or unmapped offsets are ignored. Read data is zero-extended to 32 bits.
- **Prescaler.** Counts 0..PRESCALE−1 and wraps. `tick` is asserted in the wrap cycle. PRESCALE=1 ticks every cycle.
- **PWM counter.** `cnt` is PWM_BITS wide. It advances on `tick` and wraps from 2^PWM_BITS−2 to 0, so the period is 2^PWM_BITS−1 steps.
- **Channel output.** on[i] = LED[i] & (~PWM_EN[i] | (cnt < DUTY[i])).
  - DUTY = 0 gives always off.
  - DUTY = 2^PWM_BITS−1 gives always on.
- `leds` registers `on`.
- **Read handshake.** InStrobe & Hit at edge k:
  - InData is loaded with the addressed value at edge k.
  - InRdy is 1 for exactly the cycle after edge k, then 0.
  - InData holds its value until the next read.
  - InStrobe with Hit=0 leaves InRdy at 0.
- **Simultaneous read and write** on the same cycle: both are executed. The read returns the pre-write value.
- **Back-to-back reads** on consecutive cycles are allowed. Each read yields its own one-cycle InRdy.
- **Reset values** (Reset_n low, asynchronous):
  - LED = 0, PWM_EN = 0, DUTY[i] = 2^PWM_BITS−1.
  - Prescaler = 0, cnt = 0.
  - leds = 0, InData = 0, InRdy = 0.
- **Reset release.** Operation resumes on the first rising edge after Reset_n goes high. Any read in progress when reset asserts is dropped: no InRdy is produced.

## Timing
- **Write latency.** OutStrobe sampled at edge k updates the register at edge k; `leds` reflects it at edge k+1.
- **Read latency:** 1 cycle (InRdy and InData valid after edge k).
- **PWM output latency:** `leds` follows `cnt`/DUTY changes by 1 cycle.
- **PWM period:** PRESCALE × (2^PWM_BITS−1) clocks. Default 40 × 255 = 10200 clocks (255 µs at 40 MHz).
- **Hit** is purely combinational from IOaddr and has no state.

## Test plan
- **Reset.** Assert Reset_n=0 mid-run with LED=0xFF and a read pending. Required: leds=0, InRdy=0 and InData=0 immediately, without a clock edge. After release, reading offset 8 returns 0xFF.
- **Write, set, clear, toggle.** Write 0xA5 to offset 0, then 0x0F to offset 1, 0x81 to offset 2, 0xFF to offset 3. Required: leds goes 0xA5, then 0xAF, then 0x2E, then 0xD1, each one cycle after its write. Reading offset 0 returns 0x000000D1.
- **Readback.**
  - Read offset 5 → 0x08081ED0 with a single-cycle InRdy.
  - Reads of offsets 1 and 40 → 0.
  - InStrobe with IOaddr = BASE_ADDR+64 → Hit=0 and no InRdy.
- **Read/write collision.** Write 0x3C to offset 0 and read offset 0 in the same cycle. Required: InData = the old value; the next read returns 0x3C.
- **PWM duty.** With PRESCALE=1 and PWM_BITS=4, set LED=0x07, PWM_EN=0x07, DUTY0=0, DUTY1=5, DUTY2=15. Required over a 15-cycle period: ch0 high 0 cycles, ch1 high 5 cycles, ch2 high 15 cycles.
- **PWM disable.** Clear PWM_EN bit 1. Required: ch1 is constantly high from the second edge onward.

Source files
------------

// File: rtl/io_led_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_led_bank
// Description : Memory-mapped LED/GPIO output bank for the TinyComp I/O bus.
//               It decodes a 64-word address window and provides LED, SET,
//               CLR, TOG, PWM_EN, ID and per-channel DUTY registers. Each
//               channel can be PWM-dimmed from a prescaled counter.
// Ports       : clk       - single clock, rising edge
//               Reset_n   - asynchronous active-low reset
//               IOaddr    - bus word address
//               OutData   - write data
//               OutStrobe - one-cycle write strobe
//               InStrobe  - one-cycle read strobe
//               InData    - read data, loaded on a hit read, held until next
//               InRdy     - one-cycle read-data-valid pulse
//               Hit       - combinational, IOaddr lies inside the window
//               leds      - registered channel outputs
// Revision    : 1.0 - initial release
// ============================================================================
module io_led_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_03C0,
    parameter int          NUM_LEDS  = 8,
    parameter int          PWM_BITS  = 8,
    parameter int          PRESCALE  = 40
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic [31:0]         IOaddr,
    input  logic [31:0]         OutData,
    input  logic                OutStrobe,
    input  logic                InStrobe,
    output logic [31:0]         InData,
    output logic                InRdy,
    output logic                Hit,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int                PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(PRESCALE - 1);
    // cnt wraps one step early so DUTY = all-ones keeps a channel on for
    // the whole period.
    localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [5:0]        OFF_LED    = 6'd0;
    localparam logic [5:0]        OFF_SET    = 6'd1;
    localparam logic [5:0]        OFF_CLR    = 6'd2;
    localparam logic [5:0]        OFF_TOG    = 6'd3;
    localparam logic [5:0]        OFF_PWM_EN = 6'd4;
    localparam logic [5:0]        OFF_ID     = 6'd5;
    localparam logic [31:0]       ID_VALUE   = {8'(NUM_LEDS), 8'(PWM_BITS), 16'h1ED0};

    logic [5:0]          off;
    logic                wr_en;
    logic                rd_en;
    logic [NUM_LEDS-1:0] wdata_led;
    logic [PWM_BITS-1:0] wdata_duty;

    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_LEDS-1:0] pwm_en;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];
    logic [PS_W-1:0]     presc;
    logic                tick;
    logic [PWM_BITS-1:0] cnt;
    logic [NUM_LEDS-1:0] on_vec;
    logic [31:0]         rd_data;

    // Only the low bits of the write data are meaningful for any register.
    logic unused_out_data;
    assign unused_out_data = ^OutData;

    // BASE_ADDR is 64-aligned, so the offset is simply the low six bits.
    assign Hit        = (IOaddr[31:6] == BASE_ADDR[31:6]);
    assign off        = IOaddr[5:0];
    assign wr_en      = OutStrobe & Hit;
    assign rd_en      = InStrobe & Hit;
    assign wdata_led  = OutData[NUM_LEDS-1:0];
    assign wdata_duty = OutData[PWM_BITS-1:0];

    // ------------------------------------------------------------------
    // LED and PWM enable registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            led_reg <= '0;
            pwm_en  <= '0;
        end else if (wr_en) begin
            case (off)
                OFF_LED:    led_reg <= wdata_led;
                OFF_SET:    led_reg <= led_reg | wdata_led;
                OFF_CLR:    led_reg <= led_reg & ~wdata_led;
                OFF_TOG:    led_reg <= led_reg ^ wdata_led;
                OFF_PWM_EN: pwm_en  <= wdata_led;
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM counter
    // ------------------------------------------------------------------
    assign tick = (presc == PS_LAST);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
            if (tick) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + PWM_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel duty registers and output gating
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
            localparam logic [5:0] OFF_DUTY = 6'(8 + i);

            always_ff @(posedge clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    duty[i] <= DUTY_MAX;
                end else if (wr_en && (off == OFF_DUTY)) begin
                    duty[i] <= wdata_duty;
                end
            end

            assign on_vec[i] = led_reg[i] & (~pwm_en[i] | (cnt < duty[i]));
        end
    endgenerate

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            leds <= '0;
        end else begin
            leds <= on_vec;
        end
    end

    // ------------------------------------------------------------------
    // Read path: the mux sees the pre-write register values, so a read
    // colliding with a write returns the old contents.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_LED:    rd_data[NUM_LEDS-1:0] = led_reg;
            OFF_PWM_EN: rd_data[NUM_LEDS-1:0] = pwm_en;
            OFF_ID:     rd_data               = ID_VALUE;
            default:    ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (off == 6'(8 + i)) begin
                rd_data[PWM_BITS-1:0] = duty[i];
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            InData <= '0;
            InRdy  <= 1'b0;
        end else begin
            InRdy <= rd_en;
            if (rd_en) begin
                InData <= rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_led_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_led_bank
// Description : Scoreboard bench for io_led_bank. A reference model updated
//               on every rising edge predicts leds and queues read results;
//               a monitor on the falling edge compares the DUT against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_led_bank;

    localparam int          NL     = 8;
    localparam int          PB     = 4;
    localparam int          PS     = 2;
    localparam logic [31:0] BASE   = 32'h0000_03C0;
    localparam int          STEPS  = (1 << PB) - 1;
    localparam int          PERIOD = PS * STEPS;
    localparam logic [31:0] MASK   = (32'h1 << NL) - 32'h1;
    localparam logic [31:0] DMASK  = (32'h1 << PB) - 32'h1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   io_addr = '0;
    logic [31:0]   out_data = '0;
    logic          out_strobe = 1'b0;
    logic          in_strobe = 1'b0;
    logic [31:0]   in_data;
    logic          in_rdy;
    logic          hit;
    logic [NL-1:0] leds;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0]   m_led;
    logic [31:0]   m_en;
    int            m_duty [NL];
    int unsigned   n_edges;
    logic [NL-1:0] exp_leds = '0;
    logic [31:0]   exp_indata = '0;
    logic [31:0]   rdq [$];

    io_led_bank #(
        .BASE_ADDR (BASE),
        .NUM_LEDS  (NL),
        .PWM_BITS  (PB),
        .PRESCALE  (PS)
    ) dut (
        .clk       (clk),
        .Reset_n   (rst_n),
        .IOaddr    (io_addr),
        .OutData   (out_data),
        .OutStrobe (out_strobe),
        .InStrobe  (in_strobe),
        .InData    (in_data),
        .InRdy     (in_rdy),
        .Hit       (hit),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd64);
    endfunction

    function automatic logic [31:0] model_read(input int off);
        if (off == 0) return m_led;
        if (off == 4) return m_en;
        if (off == 5) return (NL << 24) | (PB << 16) | 32'h1ED0;
        if (off >= 8 && off < 8 + NL) return 32'(m_duty[off-8]);
        return 32'h0;
    endfunction

    task automatic model_write(input int off, input logic [31:0] d);
        case (off)
            0: m_led = d & MASK;
            1: m_led = m_led | (d & MASK);
            2: m_led = m_led & ~d & MASK;
            3: m_led = (m_led ^ d) & MASK;
            4: m_en  = d & MASK;
            default: if (off >= 8 && off < 8 + NL) m_duty[off-8] = int'(d & DMASK);
        endcase
    endtask

    // Counter step seen before the (n+1)-th edge after reset: one step every
    // PS clocks, period of STEPS steps.
    function automatic logic [NL-1:0] model_on();
        logic [NL-1:0] r;
        int c;
        c = int'((n_edges / PS) % STEPS);
        for (int i = 0; i < NL; i++)
            r[i] = m_led[i] && (!m_en[i] || (c < m_duty[i]));
        return r;
    endfunction

    // Reference model: advances on every rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_led = '0;
            m_en  = '0;
            for (int i = 0; i < NL; i++) m_duty[i] = STEPS;
            n_edges  = 0;
            exp_leds = '0;
        end else begin
            exp_leds = model_on();
            if (in_strobe && in_window(io_addr))
                rdq.push_back(model_read(int'(io_addr - BASE)));
            if (out_strobe && in_window(io_addr))
                model_write(int'(io_addr - BASE), out_data);
            n_edges++;
        end
    end

    // Monitor: compares outputs on the falling edge.
    always @(negedge clk) begin
        logic exp_rdy;
        total++;
        if (leds !== exp_leds) begin
            bad++;
            $display("FAIL leds @%0t: got %0h want %0h", $time, leds, exp_leds);
        end
        exp_rdy = 1'b0;
        if (rdq.size() > 0) begin
            exp_rdy    = 1'b1;
            exp_indata = rdq.pop_front();
        end
        total++;
        if (in_rdy !== exp_rdy || in_data !== exp_indata) begin
            bad++;
            $display("FAIL read @%0t: got rdy=%0b data=%08h want rdy=%0b data=%08h",
                     $time, in_rdy, in_data, exp_rdy, exp_indata);
        end
    end

    task automatic bus(input logic [31:0] addr, input logic [31:0] data,
                       input logic wr, input logic rd);
        @(negedge clk);
        io_addr    = addr;
        out_data   = data;
        out_strobe = wr;
        in_strobe  = rd;
        #1;
        total++;
        if (hit !== in_window(addr)) begin
            bad++;
            $display("FAIL hit addr=%08h: got %0b want %0b", addr, hit, in_window(addr));
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        out_strobe = 1'b0;
        in_strobe  = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int h0, h1, h2;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Write / set / clear / toggle, then read back
        bus(BASE + 0, 32'hA5, 1, 0);
        bus(BASE + 1, 32'h0F, 1, 0);
        bus(BASE + 2, 32'h81, 1, 0);
        bus(BASE + 3, 32'hFF, 1, 0);
        bus(BASE + 0, 32'h0, 0, 1);
        idle(2);
        check("led_after_tog", int'(leds), 'hD1);

        // Readback: ID, write-only, unmapped, out of window, back-to-back
        bus(BASE + 5, 0, 0, 1);
        idle(2);
        bus(BASE + 1, 0, 0, 1);
        bus(BASE + 40, 0, 0, 1);
        bus(BASE + 64, 0, 0, 1);
        bus(BASE - 1, 0, 0, 1);
        bus(BASE + 9, 32'h7, 1, 0);
        bus(BASE + 5, 32'hFFFF_FFFF, 1, 0);
        bus(BASE + 5, 0, 0, 1);
        bus(BASE + 9, 0, 0, 1);
        idle(2);

        // Read/write collision then follow-up read
        bus(BASE + 0, 32'h3C, 1, 1);
        bus(BASE + 0, 0, 0, 1);
        idle(2);

        // PWM duty
        bus(BASE + 0, 32'h07, 1, 0);
        bus(BASE + 4, 32'h07, 1, 0);
        bus(BASE + 8, 32'h0, 1, 0);
        bus(BASE + 9, 32'h5, 1, 0);
        bus(BASE + 10, 32'hF, 1, 0);
        idle(4);
        h0 = 0; h1 = 0; h2 = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            h0 += int'(leds[0]);
            h1 += int'(leds[1]);
            h2 += int'(leds[2]);
        end
        check("duty0_high", h0, 0);
        check("duty5_high", h1, 5 * PS);
        check("duty15_high", h2, 15 * PS);

        // PWM disable on channel 1
        bus(BASE + 4, 32'h05, 1, 0);
        idle(1);
        h1 = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            h1 += int'(leds[1]);
        end
        check("pwm_off_ch1_high", h1, PERIOD);

        // Randomised traffic
        repeat (300) begin
            case ($urandom_range(9))
                0:       a = BASE + 32'd64 + $urandom_range(63);
                1:       a = BASE - 32'd1 - $urandom_range(63);
                default: a = BASE + $urandom_range(15);
            endcase
            bus(a, $urandom, 1'($urandom_range(1)), 1'($urandom_range(2) == 0));
        end
        idle(2);

        // Asynchronous reset with a read in flight
        bus(BASE + 0, 32'hFF, 1, 0);
        bus(BASE + 4, 32'h00, 1, 0);
        bus(BASE + 0, 0, 0, 1);
        @(posedge clk);
        out_strobe = 1'b0;
        in_strobe  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_leds", int'(leds), 0);
        check("rst_inrdy", int'(in_rdy), 0);
        check("rst_indata", int'(in_data), 0);
        rdq.delete();
        exp_indata = '0;
        exp_leds   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus(BASE + 8, 0, 0, 1);
        idle(2);
        check("rst_duty_read", int'(in_data), STEPS);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
